// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic LEGv8-subset instructions into 32-bit machine
// words, buffers them in a small circular FIFO and emits each word tagged with
// an auto-incrementing word address taken at pop time.
module instr_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        op,
  input  logic [4:0]        rd,
  input  logic [4:0]        rn,
  input  logic [4:0]        rm,
  input  logic [25:0]       imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [31:0]       out_instr,
  output logic [2:0]        err,
  output logic [15:0]       count
);

  localparam int PW = $clog2(DEPTH);

  localparam logic [3:0] op_addi = 4'd0;
  localparam logic [3:0] op_adds = 4'd1;
  localparam logic [3:0] op_b    = 4'd2;
  localparam logic [3:0] op_blt  = 4'd3;
  localparam logic [3:0] op_cbz  = 4'd4;
  localparam logic [3:0] op_ldur = 4'd5;
  localparam logic [3:0] op_lsl  = 4'd6;
  localparam logic [3:0] op_lsr  = 4'd7;
  localparam logic [3:0] op_mul  = 4'd8;
  localparam logic [3:0] op_stur = 4'd9;
  localparam logic [3:0] op_subs = 4'd10;

  // Pointers carry one extra wrap bit so full and empty can be told apart.
  logic [PW:0]       wr_ptr_reg;
  logic [PW:0]       rd_ptr_reg;
  logic [31:0]       mem_reg [DEPTH];
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       count_reg;
  logic [2:0]        err_reg;

  logic [31:0] word_next;
  logic        op_legal;
  logic        imm_ok;
  logic        full;
  logic        empty;
  logic        push_fire;
  logic        pop_fire;
  logic        wr_en;

  assign full  = (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]) &&
                 (wr_ptr_reg[PW] != rd_ptr_reg[PW]);
  assign empty = (wr_ptr_reg == rd_ptr_reg);

  assign in_ready  = !full;
  assign out_valid = !empty;
  assign out_addr  = addr_reg;
  assign out_instr = empty ? 32'd0 : mem_reg[rd_ptr_reg[PW-1:0]];
  assign err       = err_reg;
  assign count     = count_reg;

  assign push_fire = in_valid && in_ready;
  assign pop_fire  = out_valid && out_ready;
  // A push coinciding with start is consumed but never stored.
  assign wr_en     = push_fire && op_legal && imm_ok && !start;

  // Encode the symbolic instruction and range-check its immediate.
  always_comb begin
    word_next = 32'd0;
    op_legal  = 1'b1;
    imm_ok    = 1'b1;
    case (op)
      op_addi: begin
        word_next = {10'b1001000100, imm[11:0], rn, rd};
        imm_ok    = (imm[25:12] == 14'd0);
      end
      op_adds: word_next = {11'b10101011000, rm, 6'b000000, rn, rd};
      op_subs: word_next = {11'b11101011000, rm, 6'b000000, rn, rd};
      op_mul:  word_next = {11'b10011011000, rm, 6'b011111, rn, rd};
      op_lsl: begin
        word_next = {11'b11010011011, 5'd0, imm[5:0], rn, rd};
        imm_ok    = (imm[25:6] == 20'd0);
      end
      op_lsr: begin
        word_next = {11'b11010011010, 5'd0, imm[5:0], rn, rd};
        imm_ok    = (imm[25:6] == 20'd0);
      end
      op_ldur: begin
        word_next = {11'b11111000010, imm[8:0], 2'b00, rn, rd};
        imm_ok    = (imm[25:8] == 18'd0) || (imm[25:8] == '1);
      end
      op_stur: begin
        word_next = {11'b11111000000, imm[8:0], 2'b00, rn, rd};
        imm_ok    = (imm[25:8] == 18'd0) || (imm[25:8] == '1);
      end
      op_b:    word_next = {6'b000101, imm[25:0]};
      op_blt: begin
        word_next = {8'b01010100, imm[18:0], 5'b01011};
        imm_ok    = (imm[25:18] == 8'd0) || (imm[25:18] == '1);
      end
      op_cbz: begin
        word_next = {8'b10110100, imm[18:0], rd};
        imm_ok    = (imm[25:18] == 8'd0) || (imm[25:18] == '1);
      end
      default: op_legal = 1'b0;
    endcase
  end

  // Storage for encoded words; read combinationally at the head pointer.
  always_ff @(posedge clk) begin
    if (wr_en) mem_reg[wr_ptr_reg[PW-1:0]] <= word_next;
  end

  // FIFO pointers; reset discards buffered words at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (wr_en)    wr_ptr_reg <= wr_ptr_reg + (PW+1)'(1);
      if (pop_fire) rd_ptr_reg <= rd_ptr_reg + (PW+1)'(1);
    end
  end

  // Word address and accepted-word count; start overrides the increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_reg  <= '0;
      count_reg <= '0;
    end else if (start) begin
      addr_reg  <= base;
      count_reg <= '0;
    end else if (pop_fire) begin
      addr_reg <= addr_reg + ADDR_W'(1);
      if (count_reg != 16'hFFFF) count_reg <= count_reg + 16'd1;
    end
  end

  // Sticky error flags; start clears them but records a push it dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= 3'b000;
    end else if (start) begin
      err_reg <= {push_fire, 2'b00};
    end else if (push_fire) begin
      err_reg <= err_reg | {1'b0, op_legal && !imm_ok, !op_legal};
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: expected words go into a scoreboard
// queue when pushed and are compared, with a modelled address, on each pop.
module tb_instr_encoder;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 10;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op;
  logic [4:0]        rd, rn, rm;
  logic [25:0]       imm;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [31:0]       out_instr;
  logic [2:0]        err;
  logic [15:0]       count;

  int checks = 0;
  int errors = 0;

  logic [31:0]       exp_q [$];
  logic [ADDR_W-1:0] exp_addr;
  logic [15:0]       exp_count;
  logic [31:0]       mon_word;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base(base),
    .in_valid(in_valid), .in_ready(in_ready), .op(op), .rd(rd), .rn(rn),
    .rm(rm), .imm(imm), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_instr(out_instr), .err(err), .count(count)
  );

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Scoreboard: a handshake seen mid-cycle completes at the next rising edge.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got word %h at addr %0d, required no word", out_instr, out_addr);
      end else begin
        mon_word = exp_q.pop_front();
        if (out_instr !== mon_word) begin
          errors++;
          $display("FAIL pop_instr: got %h, required %h", out_instr, mon_word);
        end
        checks++;
        if (out_addr !== exp_addr) begin
          errors++;
          $display("FAIL pop_addr: got %0d, required %0d", out_addr, exp_addr);
        end
        $display("pop  addr=%0d instr=%h", out_addr, out_instr);
      end
      exp_addr = exp_addr + ADDR_W'(1);
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
    end
  end

  task automatic push(input logic [3:0] o, input logic [4:0] d, input logic [4:0] n,
                      input logic [4:0] m, input logic [25:0] i);
    op = o; rd = d; rn = n; rm = m; imm = i; in_valid = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        $display("push op=%0d rd=%0d rn=%0d rm=%0d imm=%h", o, d, n, m, i);
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL push_timeout: in_ready=0 for 40 cycles, required 1");
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    checks++;
    for (int c = 0; c < 60; c++) begin
      if (exp_q.size() == 0 && out_valid === 1'b0) return;
      @(posedge clk); #1;
    end
    errors++;
    $display("FAIL drain_timeout: %0d words still expected, required 0", exp_q.size());
  endtask

  task automatic do_start(input logic [ADDR_W-1:0] b);
    start = 1'b1; base = b;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = b; exp_count = 16'd0;
    $display("start base=%0d", b);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; start = 1'b0; base = '0; in_valid = 1'b0; out_ready = 1'b0;
    op = 4'd0; rd = 5'd0; rn = 5'd0; rm = 5'd0; imm = 26'd0;
    exp_addr = '0; exp_count = 16'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (in_ready !== 1'b1)   begin errors++; $display("FAIL reset_in_ready: got %b, required 1", in_ready); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL reset_out_valid: got %b, required 0", out_valid); end
    checks++; if (out_addr !== '0)     begin errors++; $display("FAIL reset_out_addr: got %0d, required 0", out_addr); end
    checks++; if (out_instr !== 32'd0) begin errors++; $display("FAIL reset_out_instr: got %h, required 0", out_instr); end
    checks++; if (err !== 3'b000)      begin errors++; $display("FAIL reset_err: got %b, required 000", err); end
    checks++; if (count !== 16'd0)     begin errors++; $display("FAIL reset_count: got %0d, required 0", count); end
  endtask

  task automatic test_addi();
    out_ready = 1'b1;
    exp_q.push_back(32'h910017E1);
    push(4'd0, 5'd1, 5'd31, 5'd0, 26'd5);
    checks++; if (out_valid !== 1'b1)         begin errors++; $display("FAIL addi_valid: got %b, required 1", out_valid); end
    checks++; if (out_addr !== 10'd0)         begin errors++; $display("FAIL addi_addr: got %0d, required 0", out_addr); end
    checks++; if (out_instr !== 32'h910017E1) begin errors++; $display("FAIL addi_instr: got %h, required 910017e1", out_instr); end
    @(posedge clk); #1;
    checks++; if (count !== 16'd1)     begin errors++; $display("FAIL addi_count: got %0d, required 1", count); end
    checks++; if (out_valid !== 1'b0)  begin errors++; $display("FAIL addi_empty: got %b, required 0", out_valid); end
  endtask

  task automatic test_alu();
    do_start(10'd0);
    out_ready = 1'b1;
    exp_q.push_back(32'hAB020023);
    exp_q.push_back(32'hEB020023);
    exp_q.push_back(32'hF85F80A4);
    push(4'd1, 5'd3, 5'd1, 5'd2, 26'd0);
    push(4'd10, 5'd3, 5'd1, 5'd2, 26'd0);
    push(4'd5, 5'd4, 5'd5, 5'd0, 26'h3FFFFF8);
    wait_drain();
    checks++; if (count !== 16'd3) begin errors++; $display("FAIL alu_count: got %0d, required 3", count); end
    checks++; if (err !== 3'b000)  begin errors++; $display("FAIL alu_err: got %b, required 000", err); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] iv;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      iv = 12'(i * 100 + 7);
      exp_q.push_back({10'b1001000100, iv, 5'(i + 2), 5'(i)});
      push(4'd0, 5'(i), 5'(i + 2), 5'd0, {14'd0, iv});
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready: got %b, required 1 at word %0d", in_ready, i); end
    end
    wait_drain();
  endtask

  task automatic test_boundaries();
    out_ready = 1'b1;
    exp_q.push_back({10'b1001000100, 12'hFFF, 5'd3, 5'd2});
    push(4'd0, 5'd2, 5'd3, 5'd0, 26'd4095);
    exp_q.push_back({11'b11010011011, 5'd0, 6'd63, 5'd5, 5'd4});
    push(4'd6, 5'd4, 5'd5, 5'd9, 26'd63);
    exp_q.push_back({11'b11010011010, 5'd0, 6'd0, 5'd5, 5'd4});
    push(4'd7, 5'd4, 5'd5, 5'd9, 26'd0);
    exp_q.push_back({11'b10011011000, 5'd11, 6'b011111, 5'd10, 5'd9});
    push(4'd8, 5'd9, 5'd10, 5'd11, 26'd0);
    exp_q.push_back({11'b11111000000, 9'd255, 2'b00, 5'd7, 5'd6});
    push(4'd9, 5'd6, 5'd7, 5'd0, 26'd255);
    exp_q.push_back({11'b11111000010, 9'h100, 2'b00, 5'd7, 5'd6});
    push(4'd5, 5'd6, 5'd7, 5'd0, 26'h3FFFF00);
    exp_q.push_back({8'b01010100, 19'h40000, 5'b01011});
    push(4'd3, 5'd0, 5'd0, 5'd0, 26'h3FC0000);
    exp_q.push_back({8'b10110100, 19'h3FFFF, 5'd8});
    push(4'd4, 5'd8, 5'd0, 5'd0, 26'h003FFFF);
    wait_drain();
    checks++; if (err !== 3'b000) begin errors++; $display("FAIL bound_err: got %b, required 000", err); end
  endtask

  task automatic test_backpressure();
    logic [31:0] first;
    out_ready = 1'b0;
    first = {10'b1001000100, 12'd40, 5'd1, 5'd20};
    for (int i = 0; i < 5; i++) exp_q.push_back({10'b1001000100, 12'(40 + i), 5'd1, 5'(20 + i)});
    for (int i = 0; i < 4; i++) push(4'd0, 5'(20 + i), 5'd1, 5'd0, 26'(40 + i));
    checks++; if (in_ready !== 1'b0)  begin errors++; $display("FAIL bp_full: in_ready got %b, required 0", in_ready); end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b, required 1", out_valid); end
    fork
      push(4'd0, 5'd24, 5'd1, 5'd0, 26'd44);
      begin
        for (int c = 0; c < 3; c++) begin
          @(posedge clk); #1;
          checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_stall: in_ready got %b, required 0", in_ready); end
          checks++; if (out_instr !== first) begin errors++; $display("FAIL bp_hold: got %h, required %h", out_instr, first); end
          checks++; if (out_addr !== exp_addr) begin errors++; $display("FAIL bp_hold_addr: got %0d, required %0d", out_addr, exp_addr); end
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_errors();
    out_ready = 1'b1;
    do_start(10'd0);
    push(4'd12, 5'd1, 5'd1, 5'd1, 26'd0);
    push(4'd0, 5'd1, 5'd1, 5'd0, 26'd4096);
    push(4'd6, 5'd1, 5'd1, 5'd0, 26'd64);
    push(4'd5, 5'd1, 5'd1, 5'd0, 26'h3FFFEFF);
    repeat (2) @(posedge clk); #1;
    checks++; if (err !== 3'b011)     begin errors++; $display("FAIL err_bits: got %b, required 011", err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL err_emit: out_valid got %b, required 0", out_valid); end
    checks++; if (count !== 16'd0)    begin errors++; $display("FAIL err_count: got %0d, required 0", count); end
  endtask

  task automatic test_start_drop();
    op = 4'd0; rd = 5'd1; rn = 5'd2; rm = 5'd0; imm = 26'd9;
    in_valid = 1'b1; start = 1'b1; base = 10'd5;
    @(posedge clk); #1;
    in_valid = 1'b0; start = 1'b0;
    exp_addr = 10'd5; exp_count = 16'd0;
    $display("start base=5 with coincident push");
    checks++; if (err !== 3'b100)     begin errors++; $display("FAIL drop_err: got %b, required 100", err); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drop_emit: out_valid got %b, required 0", out_valid); end
    checks++; if (out_addr !== 10'd5) begin errors++; $display("FAIL drop_addr: got %0d, required 5", out_addr); end
  endtask

  task automatic test_wrap();
    out_ready = 1'b0;
    do_start(10'd1023);
    exp_q.push_back(32'h17FFFFFF);
    exp_q.push_back(32'hB4000047);
    push(4'd2, 5'd0, 5'd0, 5'd0, 26'h3FFFFFF);
    push(4'd4, 5'd7, 5'd0, 5'd0, 26'd2);
    checks++; if (out_addr !== 10'd1023)      begin errors++; $display("FAIL wrap_addr: got %0d, required 1023", out_addr); end
    checks++; if (out_instr !== 32'h17FFFFFF) begin errors++; $display("FAIL wrap_instr: got %h, required 17ffffff", out_instr); end
    out_ready = 1'b1;
    wait_drain();
    checks++; if (out_addr !== 10'd1) begin errors++; $display("FAIL wrap_after: got %0d, required 1", out_addr); end
    checks++; if (count !== 16'd2)    begin errors++; $display("FAIL wrap_count: got %0d, required 2", count); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(4'd13, 5'd0, 5'd0, 5'd0, 26'd0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({10'b1001000100, 12'(i + 1), 5'd3, 5'd3});
      push(4'd0, 5'd3, 5'd3, 5'd0, 26'(i + 1));
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rm_pre_valid: got %b, required 1", out_valid); end
    checks++; if (err !== 3'b001)     begin errors++; $display("FAIL rm_pre_err: got %b, required 001", err); end
    reset_n = 1'b0;
    #1;
    $display("reset asserted mid-stream");
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rm_valid: got %b, required 0", out_valid); end
    checks++; if (err !== 3'b000)     begin errors++; $display("FAIL rm_err: got %b, required 000", err); end
    checks++; if (count !== 16'd0)    begin errors++; $display("FAIL rm_count: got %0d, required 0", count); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL rm_in_ready: got %b, required 1", in_ready); end
    exp_q.delete();
    exp_addr = '0; exp_count = 16'd0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back(32'h910017E1);
    push(4'd0, 5'd1, 5'd31, 5'd0, 26'd5);
    checks++; if (out_addr !== 10'd0) begin errors++; $display("FAIL rm_first_addr: got %0d, required 0", out_addr); end
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_addi();
    test_alu();
    test_back_to_back();
    test_boundaries();
    test_backpressure();
    test_errors();
    test_start_drop();
    test_wrap();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
